// File: rtl/keyboard.sv
// ============================================================================
//  Module      : keyboard
//  Description : PS/2 receive-only keyboard decoder; reports the held game key.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module keyboard (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [4:0] KEYSTROKE
);

    localparam logic [13:0] c_TIMEOUT = 14'd9999;
    localparam logic [3:0]  c_LAST_BIT = 4'd10;
    localparam logic [4:0]  c_NONE = 5'b11111;

    logic        r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic [2:0]  r_filt_cnt;
    logic        r_filt_clk;
    logic [9:0]  r_shift;
    logic [3:0]  r_bitcnt;
    logic [13:0] r_to_cnt;
    logic        r_byte_valid;
    logic [7:0]  r_byte;
    logic        r_ext, r_brk;
    logic [4:0]  r_keystroke;

    logic        w_fall;
    logic [10:0] w_frame;
    logic        w_frame_ok;
    logic [4:0]  w_code;
    logic        w_hit;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= PS2_CLK;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= PS2_DATA;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Filtered level flips on the 8th consecutive sample that disagrees with it
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_filt_cnt <= 3'd0;
            r_filt_clk <= 1'b1;
        end else if (r_clk_s2 == r_filt_clk) begin
            r_filt_cnt <= 3'd0;
        end else if (r_filt_cnt == 3'd7) begin
            r_filt_cnt <= 3'd0;
            r_filt_clk <= ~r_filt_clk;
        end else begin
            r_filt_cnt <= r_filt_cnt + 3'd1;
        end
    end

    assign w_fall     = r_filt_clk && (r_clk_s2 != r_filt_clk) && (r_filt_cnt == 3'd7);
    assign w_frame    = {r_dat_s2, r_shift};
    assign w_frame_ok = !w_frame[0] && w_frame[10] && (^w_frame[9:1]);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_shift      <= 10'd0;
            r_bitcnt     <= 4'd0;
            r_to_cnt     <= 14'd0;
            r_byte_valid <= 1'b0;
            r_byte       <= 8'd0;
        end else begin
            r_byte_valid <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= 14'd0;
                r_shift  <= {r_dat_s2, r_shift[9:1]};
                if (r_bitcnt == c_LAST_BIT) begin
                    r_bitcnt     <= 4'd0;
                    r_byte_valid <= w_frame_ok;
                    r_byte       <= w_frame[8:1];
                end else begin
                    r_bitcnt <= r_bitcnt + 4'd1;
                end
            end else if (r_bitcnt != 4'd0) begin
                // A stalled partial frame is dropped so the next start bit realigns
                if (r_to_cnt == c_TIMEOUT) begin
                    r_to_cnt <= 14'd0;
                    r_bitcnt <= 4'd0;
                end else begin
                    r_to_cnt <= r_to_cnt + 14'd1;
                end
            end else begin
                r_to_cnt <= 14'd0;
            end
        end
    end

    always_comb begin
        w_code = c_NONE;
        w_hit  = 1'b0;
        case ({r_ext, r_byte})
            9'h01D: begin w_code = 5'b00000; w_hit = 1'b1; end
            9'h01B: begin w_code = 5'b00001; w_hit = 1'b1; end
            9'h01C: begin w_code = 5'b00010; w_hit = 1'b1; end
            9'h023: begin w_code = 5'b00011; w_hit = 1'b1; end
            9'h175: begin w_code = 5'b00100; w_hit = 1'b1; end
            9'h172: begin w_code = 5'b00101; w_hit = 1'b1; end
            9'h16B: begin w_code = 5'b00110; w_hit = 1'b1; end
            9'h174: begin w_code = 5'b00111; w_hit = 1'b1; end
            9'h029: begin w_code = 5'b01000; w_hit = 1'b1; end
            9'h05A: begin w_code = 5'b01001; w_hit = 1'b1; end
            default: begin w_code = c_NONE; w_hit = 1'b0; end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_keystroke <= c_NONE;
        end else if (r_byte_valid) begin
            if (r_byte == 8'hE0) begin
                r_ext <= 1'b1;
            end else if (r_byte == 8'hF0) begin
                r_brk <= 1'b1;
            end else begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
                if (w_hit) begin
                    if (!r_brk) begin
                        r_keystroke <= w_code;
                    end else if (w_code == r_keystroke) begin
                        r_keystroke <= c_NONE;
                    end
                end
            end
        end
    end

    assign KEYSTROKE = r_keystroke;

endmodule

`default_nettype wire

// File: tb/tb_keyboard.sv
// ============================================================================
//  Module      : tb_keyboard
//  Description : Bench for keyboard: directed vector table plus random frames.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_keyboard;

    localparam int c_HALF = 25;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       PS2_CLK  = 1'b1;
    logic       PS2_DATA = 1'b1;
    logic [4:0] KEYSTROKE;

    int n_checks = 0;
    int n_fail   = 0;

    int   keymap[int];
    bit   m_ext, m_brk;
    logic [4:0] m_ks;

    typedef struct {
        logic [7:0] b;
        int         err;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[17];

    keyboard dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DATA  (PS2_DATA),
        .KEYSTROKE (KEYSTROKE)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [4:0] exp);
        n_checks++;
        if (KEYSTROKE !== exp) begin
            n_fail++;
            $display("FAIL %s: KEYSTROKE=%b expected %b", name, KEYSTROKE, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // err: 0 good, 1 parity flipped, 2 stop bit low, 3 start bit high
    function automatic logic [10:0] make_frame(input logic [7:0] b, input int err);
        logic par;
        par = ~(^b);
        if (err == 1) par = ~par;
        return {(err == 2) ? 1'b0 : 1'b1, par, b, (err == 3) ? 1'b1 : 1'b0};
    endfunction

    task automatic model_reset();
        m_ext = 0;
        m_brk = 0;
        m_ks  = 5'b11111;
    endtask

    task automatic model_byte(input logic [7:0] b, input int err);
        int k;
        if (err != 0) return;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            k = (m_ext ? 256 : 0) + int'(b);
            if (keymap.exists(k)) begin
                if (!m_brk) m_ks = 5'(keymap[k]);
                else if (m_ks == 5'(keymap[k])) m_ks = 5'b11111;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    // Checks KEYSTROKE 12 system cycles after the stop-bit falling edge
    task automatic send_bits(input logic [10:0] fr, input int nbits, input bit do_check,
                             input logic [4:0] exp, input string name);
        for (int i = 0; i < nbits; i++) begin
            @(negedge CLOCK_50);
            PS2_DATA = fr[i];
            wait_cyc(c_HALF);
            PS2_CLK = 1'b0;
            if (i == 10 && do_check) begin
                repeat (12) @(posedge CLOCK_50);
                #1 check(name, exp);
                wait_cyc(c_HALF - 12);
            end else begin
                wait_cyc(c_HALF);
            end
            PS2_CLK = 1'b1;
        end
        PS2_DATA = 1'b1;
        wait_cyc(c_HALF);
    endtask

    task automatic send_byte(input logic [7:0] b, input int err, input logic [4:0] exp,
                             input string name);
        send_bits(make_frame(b, err), 11, 1'b1, exp, name);
    endtask

    initial begin
        logic [7:0] pool[13];
        logic [7:0] b;
        int err;

        keymap[32'h01D] = 0;  keymap[32'h01B] = 1;  keymap[32'h01C] = 2;  keymap[32'h023] = 3;
        keymap[32'h175] = 4;  keymap[32'h172] = 5;  keymap[32'h16B] = 6;  keymap[32'h174] = 7;
        keymap[32'h029] = 8;  keymap[32'h05A] = 9;
        pool = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74,
                 8'h29, 8'h5A, 8'h00};

        tbl = '{
            '{8'h1D, 0, 5'b00000}, '{8'hF0, 0, 5'b00000}, '{8'h1D, 0, 5'b11111},
            '{8'hE0, 0, 5'b11111}, '{8'h75, 0, 5'b00100}, '{8'hE0, 0, 5'b00100},
            '{8'h6B, 0, 5'b00110}, '{8'hE0, 0, 5'b00110}, '{8'hF0, 0, 5'b00110},
            '{8'h75, 0, 5'b00110}, '{8'hE0, 0, 5'b00110}, '{8'hF0, 0, 5'b00110},
            '{8'h6B, 0, 5'b11111}, '{8'h1C, 1, 5'b11111}, '{8'h1C, 0, 5'b00010},
            '{8'h75, 0, 5'b00010}, '{8'h29, 0, 5'b01000}
        };

        model_reset();
        wait_cyc(5);
        #1 check("reset_value", 5'b11111);
        reset = 1'b0;
        wait_cyc(20);
        check("idle_after_reset", 5'b11111);

        foreach (tbl[i]) begin
            send_byte(tbl[i].b, tbl[i].err, tbl[i].exp, $sformatf("vec%0d", i));
            model_byte(tbl[i].b, tbl[i].err);
        end

        // One-cycle reset while a key is held
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        check("reset_1cycle", 5'b11111);
        model_reset();

        // Partial frame then long idle: timeout must realign
        send_bits(make_frame(8'h23, 0), 5, 1'b0, 5'b11111, "");
        check("partial_frame", 5'b11111);
        wait_cyc(15000);
        send_byte(8'h23, 0, 5'b00011, "after_timeout");
        model_byte(8'h23, 0);

        // Short clock glitches during idle must not shift bits
        for (int g = 0; g < 6; g++) begin
            @(negedge CLOCK_50);
            PS2_CLK = 1'b0;
            wait_cyc(2);
            PS2_CLK = 1'b1;
            wait_cyc(15);
        end
        check("glitch_idle", 5'b00011);
        send_byte(8'h1B, 0, 5'b00001, "after_glitch");
        model_byte(8'h1B, 0);

        // Reset in mid-frame discards the partial bits
        send_bits(make_frame(8'h5A, 0), 4, 1'b0, 5'b11111, "");
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        model_reset();
        send_byte(8'h1D, 0, 5'b00000, "after_midframe_reset");
        model_byte(8'h1D, 0);

        for (int r = 0; r < 40; r++) begin
            b = pool[$urandom_range(12)];
            if (b == 8'h00) b = 8'($urandom);
            err = ($urandom_range(9) == 0) ? int'($urandom_range(3, 1)) : 0;
            model_byte(b, err);
            send_byte(b, err, m_ks, $sformatf("rand%0d_%02h", r, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/keyboard.md
KEYBOARD -- requirements
Module: keyboard

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high.
REQ-002 CLOCK_50  input  1  system clock, 50 MHz; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 PS2_CLK  input  1  PS/2 device clock, asynchronous to CLOCK_50, idle high.
REQ-005 PS2_DATA  input  1  PS/2 device data, asynchronous, idle high.
REQ-006 KEYSTROKE  output  5  registered code of the currently held game key; 5'b11111 = none.

Function
REQ-007 PS2_CLK and PS2_DATA SHALL each pass through a 2-flop synchronizer before any use.
REQ-008 Synchronized PS2_CLK SHALL be glitch-filtered: the filtered level changes only after 8 consecutive equal samples.
REQ-009 A falling edge of the filtered clock SHALL sample synchronized PS2_DATA into an 11-bit frame: start(0), 8 data bits LSB first, odd parity, stop(1).
REQ-010 A frame SHALL be accepted only if start=0, stop=1 and odd parity holds across the data bits plus parity bit; otherwise it SHALL be discarded silently with no state change.
REQ-011 If no filtered falling edge occurs for 10000 consecutive cycles (200 us) mid-frame, the partial frame SHALL be discarded and the bit counter cleared.
REQ-012 Decoder flags: byte E0 sets the ext flag; byte F0 sets the brk flag; both flags clear after the next non-prefix byte is processed.
REQ-013 Make-code map (Set 2): 1D->00000, 1B->00001, 1C->00010, 23->00011 (player 2 W/S/A/D = up/down/left/right).
REQ-014 Extended map (ext flag set): 75->00100, 72->00101, 6B->00110, 74->00111 (player 1 arrow up/down/left/right).
REQ-015 Other map: 29 (space)->01000, 5A (enter)->01001.
REQ-016 Make of a mapped key SHALL set KEYSTROKE to its code, replacing any prior code (last pressed wins).
REQ-017 Break (brk flag set) of the key whose code is currently on KEYSTROKE SHALL set KEYSTROKE to 11111; break of any other key SHALL leave KEYSTROKE unchanged.
REQ-018 Unmapped bytes, and mapped codes with the wrong ext state (e.g. 75 without E0), SHALL be ignored apart from clearing the flags.
REQ-019 Typematic repeats of the held key SHALL re-write the same code, producing no visible change.
REQ-020 KEYSTROKE SHALL update no later than 12 CLOCK_50 cycles after the PS2_CLK falling edge that samples the stop bit, and SHALL hold stable between updates.
REQ-021 The module SHALL never drive PS2_CLK or PS2_DATA (receive only).

Reset
REQ-022 While reset=1: KEYSTROKE=11111, bit counter=0, frame shift register cleared, ext/brk flags cleared, timeout counter=0, filtered clock level=1.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame; decoding restarts at the next start bit after reset deasserts.

Verification
REQ-024 Send frame 1D (parity 1) -> KEYSTROKE=00000 within 12 cycles of the stop edge; then F0,1D -> KEYSTROKE=11111.
REQ-025 Send E0,75 -> 00100; send E0,6B -> 00110; send E0,F0,75 -> KEYSTROKE stays 00110; send E0,F0,6B -> 11111.
REQ-026 Send 1C with wrong parity bit -> KEYSTROKE stays 11111; then valid 1C -> 00010.
REQ-027 Send 5 bits of a frame, idle 300 us, then full frame 23 -> KEYSTROKE=00011 (no misalignment).
REQ-028 Send 75 without E0 -> KEYSTROKE unchanged; send 29 -> 01000; assert reset for 1 cycle -> 11111 on next edge.
REQ-029 Inject 2-cycle low glitches on PS2_CLK during idle, then frame 1B -> KEYSTROKE=00001 only.
